// File: rtl/speck_pkg.sv
// speck_pkg: shared constants, FSM state encoding and 16-bit rotate helpers
// used by the SPECK32/64 round scheduler and its key-register bank.
package speck_pkg;

  localparam int SPECK_W      = 16;
  localparam int SPECK_ROUNDS = 22;
  localparam int SPECK_ALPHA  = 7;
  localparam int SPECK_BETA   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND  = 2'd1,
    KEY  = 2'd2,
    DONE = 2'd3
  } speck_state_e;

  // Rotate right: shift a doubled copy so the wrapped bits fall into the low word.
  function automatic logic [SPECK_W-1:0] rotr16(input logic [SPECK_W-1:0] v, input int n);
    logic [2*SPECK_W-1:0] dbl;
    dbl = {v, v} >> (n % SPECK_W);
    return dbl[SPECK_W-1:0];
  endfunction

  // Rotate left: shift a doubled copy so the wrapped bits fall into the high word.
  function automatic logic [SPECK_W-1:0] rotl16(input logic [SPECK_W-1:0] v, input int n);
    logic [2*SPECK_W-1:0] dbl;
    dbl = {v, v} << (n % SPECK_W);
    return dbl[2*SPECK_W-1:SPECK_W];
  endfunction

endpackage

// File: rtl/speck_key_regs.sv
// speck_key_regs: key-schedule register bank (k, l0, l1, l2) for SPECK32/64.
// The controller loads the whole key on accept and, on each key step, supplies
// the freshly computed l value; this block rotates/mixes k and shifts the l words.
module speck_key_regs
  import speck_pkg::*;
#(
  parameter int BETA = SPECK_BETA
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [63:0]        i_key,
  input  logic               i_upd,
  input  logic [SPECK_W-1:0] i_nl,
  output logic [SPECK_W-1:0] o_k,
  output logic [SPECK_W-1:0] o_l0
);

  logic [SPECK_W-1:0] r_k;
  logic [SPECK_W-1:0] r_l0;
  logic [SPECK_W-1:0] r_l1;
  logic [SPECK_W-1:0] r_l2;

  // Load the key words on accept, otherwise advance the schedule one step on update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k  <= 16'h0000;
      r_l0 <= 16'h0000;
      r_l1 <= 16'h0000;
      r_l2 <= 16'h0000;
    end else if (i_load) begin
      r_k  <= i_key[15:0];
      r_l0 <= i_key[31:16];
      r_l1 <= i_key[47:32];
      r_l2 <= i_key[63:48];
    end else if (i_upd) begin
      r_k  <= rotl16(r_k, BETA) ^ i_nl;
      r_l0 <= r_l1;
      r_l1 <= r_l2;
      r_l2 <= i_nl;
    end
  end

  assign o_k  = r_k;
  assign o_l0 = r_l0;

endmodule

// File: rtl/speck_round_sched_chk.sv
// speck_round_sched_chk: protocol checker for the round scheduler handshakes
// and round counter range. Holds assertions only; drives nothing.
module speck_round_sched_chk #(
  parameter int ROUNDS = 22,
  parameter int RND_W  = 5
)
(
  input logic             clk,
  input logic             rst_n,
  input logic             i_in_ready,
  input logic             i_out_valid,
  input logic             i_out_ready,
  input logic [31:0]      i_ct,
  input logic [RND_W-1:0] i_rnd
);

  // Idle and done are distinct states, so the two flags never overlap.
  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_in_ready && i_out_valid));

  // The round counter stays inside the round range for the whole operation.
  a_rnd_range: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(i_rnd) < ROUNDS));

  // A stalled result keeps both valid and data stable.
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (i_out_valid && !i_out_ready) |=> (i_out_valid && $stable(i_ct)));

  // A completed output handshake returns to idle on the following cycle.
  a_out_return: assert property (@(posedge clk) disable iff (!rst_n)
    (i_out_valid && i_out_ready) |=> (i_in_ready && !i_out_valid));

endmodule

// File: rtl/speck_round_sched.sv
// speck_round_sched: sequencing controller for one SPECK32/64 encryption.
// A single external 16-bit adder is time-shared: RND cycles add for the round
// function, KEY cycles add for the key schedule. The schedule is skipped after
// the last round, so a block takes 2*ROUNDS-1 cycles from accept to result.
// Optional build macro: SPECK_SCHED_ARB_EN adds an external adder requester that
// is served only while the cipher is idle or holding its result.
module speck_round_sched
  import speck_pkg::*;
#(
  parameter int ROUNDS = SPECK_ROUNDS,
  parameter int ALPHA  = SPECK_ALPHA,
  parameter int BETA   = SPECK_BETA
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pt,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ct,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum
`ifdef SPECK_SCHED_ARB_EN
  ,
  input  logic        ext_req,
  input  logic [15:0] ext_a,
  input  logic [15:0] ext_b,
  output logic        ext_gnt,
  output logic [15:0] ext_sum
`endif
);

  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  speck_state_e r_state;
  speck_state_e w_next_state;

  logic [SPECK_W-1:0] r_x;
  logic [SPECK_W-1:0] r_y;
  logic [RND_W-1:0]   r_rnd;

  logic               w_key_load;
  logic               w_key_upd;
  logic               w_last;
  logic [SPECK_W-1:0] w_k;
  logic [SPECK_W-1:0] w_l0;
  logic [SPECK_W-1:0] w_new_x;
  logic [SPECK_W-1:0] w_nl;
  logic [SPECK_W-1:0] w_cipher_a;
  logic [SPECK_W-1:0] w_cipher_b;

  assign w_last  = (r_rnd == LAST_RND);
  // Both results are only meaningful in the state that drives the matching operands.
  assign w_new_x = add_sum ^ w_k;
  assign w_nl    = add_sum ^ SPECK_W'(r_rnd);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus key-bank load/update strobes.
  always_comb begin
    w_next_state = r_state;
    w_key_load   = 1'b0;
    w_key_upd    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next_state = RND;
          w_key_load   = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      RND: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = KEY;
        end
      end
      KEY: begin
        w_next_state = RND;
        w_key_upd    = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Cipher state x/y and round counter; the counter advances once per key step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= 16'h0000;
      r_y   <= 16'h0000;
      r_rnd <= {RND_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x   <= pt[31:16];
            r_y   <= pt[15:0];
            r_rnd <= {RND_W{1'b0}};
          end
        end
        RND: begin
          r_x <= w_new_x;
          r_y <= rotl16(r_y, BETA) ^ w_new_x;
        end
        KEY: begin
          r_rnd <= r_rnd + RND_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Cipher-side adder operands: round function in RND, key schedule in KEY.
  always_comb begin
    w_cipher_a = 16'h0000;
    w_cipher_b = 16'h0000;
    case (r_state)
      RND: begin
        w_cipher_a = rotr16(r_x, ALPHA);
        w_cipher_b = r_y;
      end
      KEY: begin
        w_cipher_a = rotr16(w_l0, ALPHA);
        w_cipher_b = w_k;
      end
      default: begin
        w_cipher_a = 16'h0000;
        w_cipher_b = 16'h0000;
      end
    endcase
  end

`ifdef SPECK_SCHED_ARB_EN
  logic w_ext_gnt;

  // External requester is served only while the cipher leaves the adder free.
  always_comb begin
    w_ext_gnt = 1'b0;
    if ((r_state == IDLE) || (r_state == DONE)) begin
      w_ext_gnt = ext_req;
    end else begin
      w_ext_gnt = 1'b0;
    end
  end

  assign ext_gnt = w_ext_gnt;
  assign ext_sum = w_ext_gnt ? add_sum : 16'h0000;
  assign add_a   = w_ext_gnt ? ext_a : w_cipher_a;
  assign add_b   = w_ext_gnt ? ext_b : w_cipher_b;
`else
  assign add_a = w_cipher_a;
  assign add_b = w_cipher_b;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign ct        = (r_state == DONE) ? {r_x, r_y} : 32'h0000_0000;

  speck_key_regs #(
    .BETA (BETA)
  ) u_key_regs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_key_load),
    .i_key  (key),
    .i_upd  (w_key_upd),
    .i_nl   (w_nl),
    .o_k    (w_k),
    .o_l0   (w_l0)
  );

  speck_round_sched_chk #(
    .ROUNDS (ROUNDS),
    .RND_W  (RND_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_ready  (in_ready),
    .i_out_valid (out_valid),
    .i_out_ready (out_ready),
    .i_ct        (ct),
    .i_rnd       (r_rnd)
  );

endmodule

// File: doc/speck_round_sched.md
Name: speck_round_sched

Overview:
- Sequencing controller for one SPECK32/64 encryption. A single external 16-bit ripple-carry adder (combinational, carry-in 0, carry-out unused) is time-shared between the round function and the key schedule.
- The block holds the x/y state and k/l key registers, steers adder operands each cycle, and counts rounds.
- Valid/ready on input and output. Sits between the SPECK top-level and the shared adder instance.

Parameters:
- ROUNDS, 22, number of SPECK rounds (22 for SPECK32/64).
- ALPHA, 7, right-rotate amount applied to x and l before the add.
- BETA, 2, left-rotate amount applied to y and k after the add.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  plaintext/key valid.
- in_ready  out  1  block idle, can accept.
- pt  in  32  plaintext {x,y}, x = pt[31:16].
- key  in  64  key {l2,l1,l0,k0}, k0 = key[15:0].
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- ct  out  32  ciphertext {x,y}.
- add_a  out  16  shared adder operand A.
- add_b  out  16  shared adder operand B.
- add_sum  in  16  shared adder result, same-cycle combinational.

Behaviour:
- Reset (async, rst_n low): state IDLE, round counter 0, all data registers 0. Outputs: in_ready=1, out_valid=0, ct=0, add_a=0, add_b=0. Deasserting rst_n mid-encryption discards the operation; no partial output.
- States: IDLE, RND, KEY, DONE.
- in_ready = (state==IDLE). in_valid while not IDLE is ignored.
- IDLE, on in_valid: load x,y,k,l0,l1,l2 and rnd=0, then go to RND. Adder is not used in the accept cycle.
- RND:
  - add_a = rotr(x,ALPHA), add_b = y.
  - Update x' = add_sum ^ k, y' = rotl(y,BETA) ^ x'.
  - If rnd==ROUNDS-1, go to DONE; otherwise go to KEY.
- KEY:
  - add_a = rotr(l0,ALPHA), add_b = k.
  - Compute nl = add_sum ^ {zero-extended rnd}.
  - Update k' = rotl(k,BETA) ^ nl; l0<=l1, l1<=l2, l2<=nl; rnd<=rnd+1; go to RND.
- Arithmetic is mod 2^16; the adder carry-out is discarded.
- The key schedule is skipped after the final round.
- DONE:
  - out_valid=1 and ct={x,y}, both held stable until out_ready.
  - out_valid & out_ready moves to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- Latency: out_valid rises 2*ROUNDS-1 = 43 rising edges after the accept edge. Throughput is one block per at least 45 cycles.
- add_a/add_b drive 0 in IDLE and DONE.
- Round counter width is clog2(ROUNDS); it never wraps within an operation.

Optional Feature:
- Macro: SPECK_SCHED_ARB_EN.
- With the macro defined, the block adds a second requester for the shared adder:
  - ports ext_req (in 1), ext_a (in 16), ext_b (in 16), ext_gnt (out 1), ext_sum (out 16).
  - ext_gnt = ext_req & (state==IDLE | state==DONE), combinational.
  - When granted, add_a/add_b = ext_a/ext_b, and ext_sum = add_sum.
  - The cipher keeps absolute priority in RND and KEY; ext_gnt=0 there.
  - ext_sum is 0 when ext_gnt=0.
  - In IDLE, acceptance of in_valid is unaffected by ext_req.
- Without the macro: the ports are absent and add_a/add_b are 0 outside RND/KEY.

Decomposition:
- Package speck_pkg holds:
  - constants SPECK_W=16, SPECK_ROUNDS=22, SPECK_ALPHA=7, SPECK_BETA=2.
  - state enum {IDLE,RND,KEY,DONE}.
  - functions rotr16/rotl16.
- One sub-module is natural: speck_key_regs, holding k/l0/l1/l2 with load and shift/update enables driven by the FSM.

Test Plan:
- Standard vector: key=0x1918111009080100, pt=0x6574694c -> ct=0xa86842f2, out_valid exactly 43 edges after accept, add_a/add_b alternate round/key operands every cycle.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> ct and out_valid stable, in_ready=0. Raise out_ready -> IDLE, in_ready=1 one cycle later.
- Busy ignore: pulse in_valid with a different pt during RND/KEY -> no effect, ct still 0xa86842f2.
- Async reset mid-operation: drop rst_n at round 10 -> immediately in_ready=1, out_valid=0, add_a=add_b=0. Fresh encryption of the standard vector gives the correct ct.
- All-zero key and pt -> ct matches the software model. Back-to-back encryptions of two vectors give correct results in order, with no state leakage.
- SPECK_SCHED_ARB_EN: ext_req with ext_a=0xFFFF, ext_b=0x0002 in IDLE -> ext_gnt=1, ext_sum=0x0001. Same request during RND -> ext_gnt=0 and the cipher result is unchanged.
